// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB source-side arbiter.
//   NUM_CDB_SRC / NUM_CDB_SLOT : six completing FU ports, two broadcast slots
//   PR_W / AR_W                : physical / architectural register tag widths
//   SRC_*                      : source index of each FU port on the bus
//   cdb_entry_t                : one queued completion {pr, ar, exc}
`ifndef SD
`define SD
`endif

package cdb_arbiter_pkg;

    localparam int unsigned NUM_CDB_SRC  = 6;
    localparam int unsigned NUM_CDB_SLOT = 2;
    localparam int unsigned PR_W         = 7;
    localparam int unsigned AR_W         = 5;
    localparam int unsigned SRC_W        = 3;

    localparam logic [SRC_W-1:0] SRC_SIM0 = 3'd0;
    localparam logic [SRC_W-1:0] SRC_SIM1 = 3'd1;
    localparam logic [SRC_W-1:0] SRC_MUL0 = 3'd2;
    localparam logic [SRC_W-1:0] SRC_MUL1 = 3'd3;
    localparam logic [SRC_W-1:0] SRC_MEM0 = 3'd4;
    localparam logic [SRC_W-1:0] SRC_MEM1 = 3'd5;

    // Multipliers never raise exceptions; their exception bit is forced to 0.
    localparam logic [NUM_CDB_SRC-1:0] EXC_KEEP_MASK = 6'b110011;

    typedef struct packed {
        logic [PR_W-1:0] pr;
        logic [AR_W-1:0] ar;
        logic            exc;
    } cdb_entry_t;

    // Next source index, wrapping 5 -> 0.
    function automatic logic [SRC_W-1:0] src_wrap_inc(input logic [SRC_W-1:0] idx);
        return (idx == SRC_MEM1) ? SRC_SIM0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of FU-side push signals and the two-wide CDB broadcast outputs.
//   src_valid/src_pr_idx/src_ar_idx/src_exception : per-source push request + payload
//   src_ready                                      : per-source backpressure
//   cdb_valid, cdb_*_tag0/1, cdb_exception0/1,
//   cdb_src0/1                                     : registered broadcast slots
//   overflow                                       : sticky dropped-push flag
// master: FU/consumer side. slave: the arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_CDB_SRC-1:0]      src_valid;
    logic [NUM_CDB_SRC*PR_W-1:0] src_pr_idx;
    logic [NUM_CDB_SRC*AR_W-1:0] src_ar_idx;
    logic [NUM_CDB_SRC-1:0]      src_exception;
    logic [NUM_CDB_SRC-1:0]      src_ready;

    logic [NUM_CDB_SLOT-1:0]     cdb_valid;
    logic [PR_W-1:0]             cdb_pr_tag0;
    logic [PR_W-1:0]             cdb_pr_tag1;
    logic [AR_W-1:0]             cdb_ar_tag0;
    logic [AR_W-1:0]             cdb_ar_tag1;
    logic                        cdb_exception0;
    logic                        cdb_exception1;
    logic [SRC_W-1:0]            cdb_src0;
    logic [SRC_W-1:0]            cdb_src1;
    logic                        overflow;

    modport master (
        output src_valid, src_pr_idx, src_ar_idx, src_exception,
        input  src_ready,
        input  cdb_valid, cdb_pr_tag0, cdb_pr_tag1, cdb_ar_tag0, cdb_ar_tag1,
        input  cdb_exception0, cdb_exception1, cdb_src0, cdb_src1, overflow
    );

    modport slave (
        input  src_valid, src_pr_idx, src_ar_idx, src_exception,
        output src_ready,
        output cdb_valid, cdb_pr_tag0, cdb_pr_tag1, cdb_ar_tag0, cdb_ar_tag1,
        output cdb_exception0, cdb_exception1, cdb_src0, cdb_src1, overflow
    );

endinterface

// File: rtl/cdb_src_queue.sv
// Two-entry FIFO holding completions from one functional unit.
//   clock, reset (sync, active-high), flush (sync squash)
//   push, push_data : write request; dropped when the queue is full
//   pop, head_data  : oldest entry and its removal strobe
//   count, ready    : occupancy (0..2) and ready = not full, from registered state only
`ifndef SD
`define SD
`endif

module cdb_src_queue
    import cdb_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t push_data,
    input  logic       pop,
    output cdb_entry_t head_data,
    output logic [1:0] count,
    output logic       ready
);

    cdb_entry_t mem_q [2];
    logic       head_q;
    logic [1:0] count_q;

    logic push_ok;
    logic pop_ok;
    logic wr_ptr;

    always_comb begin
        ready   = (count_q != 2'd2);
        push_ok = push & ready;
        pop_ok  = pop & (count_q != 2'd0);
        // Tail sits one past head when one entry is held, so a same-cycle
        // push lands behind the entry being popped.
        wr_ptr  = head_q ^ count_q[0];
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q[0] <= `SD '0;
            mem_q[1] <= `SD '0;
            head_q   <= `SD 1'b0;
            count_q  <= `SD 2'd0;
        end else if (flush) begin
            head_q   <= `SD 1'b0;
            count_q  <= `SD 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr] <= `SD push_data;
            end
            if (pop_ok) begin
                head_q <= `SD ~head_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= `SD count_q + 2'd1;
                2'b01:   count_q <= `SD count_q - 2'd1;
                default: count_q <= `SD count_q;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB source-side front end: six per-source queues feeding a round-robin
// two-grant selector whose winners are registered onto the two CDB slots.
//   clock, reset (sync, active-high), flush (sync squash of queues and valids)
//   bus : cdb_arbiter_if.slave carrying push inputs, src_ready, CDB slots, overflow
`ifndef SD
`define SD
`endif

module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);

    cdb_entry_t             push_data [NUM_CDB_SRC];
    cdb_entry_t             head_data [NUM_CDB_SRC];
    logic [1:0]             count     [NUM_CDB_SRC];
    logic [NUM_CDB_SRC-1:0] req;
    logic [NUM_CDB_SRC-1:0] pop;
    logic [NUM_CDB_SRC-1:0] ready;

    for (genvar i = 0; i < NUM_CDB_SRC; i++) begin : g_src
        assign push_data[i] = '{
            pr:  bus.src_pr_idx[PR_W*i +: PR_W],
            ar:  bus.src_ar_idx[AR_W*i +: AR_W],
            exc: bus.src_exception[i] & EXC_KEEP_MASK[i]
        };
        assign req[i] = (count[i] != 2'd0);

        cdb_src_queue u_queue (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .push      (bus.src_valid[i]),
            .push_data (push_data[i]),
            .pop       (pop[i]),
            .head_data (head_data[i]),
            .count     (count[i]),
            .ready     (ready[i])
        );
    end

    // Round-robin state and registered outputs.
    logic [SRC_W-1:0]        rr_q, rr_d;
    logic                    overflow_q, overflow_d;
    logic [NUM_CDB_SLOT-1:0] cdb_valid_q;
    cdb_entry_t              slot0_q, slot1_q;
    logic [SRC_W-1:0]        src0_q, src1_q;

    // Two-grant selector.
    logic             grant0_vld, grant1_vld;
    logic [SRC_W-1:0] grant0_idx, grant1_idx;
    logic [SRC_W-1:0] scan_idx;

    always_comb begin
        grant0_vld = 1'b0;
        grant1_vld = 1'b0;
        grant0_idx = '0;
        grant1_idx = '0;
        scan_idx   = rr_q;
        // Walk all six sources once, starting at rr_q; first two non-empty win.
        for (int unsigned off = 0; off < NUM_CDB_SRC; off++) begin
            if (req[scan_idx]) begin
                if (!grant0_vld) begin
                    grant0_vld = 1'b1;
                    grant0_idx = scan_idx;
                end else if (!grant1_vld) begin
                    grant1_vld = 1'b1;
                    grant1_idx = scan_idx;
                end
            end
            scan_idx = src_wrap_inc(scan_idx);
        end
    end

    always_comb begin
        pop = '0;
        if (grant0_vld) begin
            pop[grant0_idx] = 1'b1;
        end
        if (grant1_vld) begin
            pop[grant1_idx] = 1'b1;
        end

        if (grant1_vld) begin
            rr_d = src_wrap_inc(grant1_idx);
        end else if (grant0_vld) begin
            rr_d = src_wrap_inc(grant0_idx);
        end else begin
            rr_d = rr_q;
        end

        overflow_d = overflow_q | (|(bus.src_valid & ~ready));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q        <= `SD '0;
            overflow_q  <= `SD 1'b0;
            cdb_valid_q <= `SD '0;
            slot0_q     <= `SD '0;
            slot1_q     <= `SD '0;
            src0_q      <= `SD '0;
            src1_q      <= `SD '0;
        end else if (flush) begin
            // Pushes and pops of this cycle are discarded; rr_q and overflow hold.
            cdb_valid_q <= `SD '0;
        end else begin
            rr_q        <= `SD rr_d;
            overflow_q  <= `SD overflow_d;
            cdb_valid_q <= `SD {grant1_vld, grant0_vld};
            if (grant0_vld) begin
                slot0_q <= `SD head_data[grant0_idx];
                src0_q  <= `SD grant0_idx;
            end
            if (grant1_vld) begin
                slot1_q <= `SD head_data[grant1_idx];
                src1_q  <= `SD grant1_idx;
            end
        end
    end

    assign bus.src_ready      = ready;
    assign bus.cdb_valid      = cdb_valid_q;
    assign bus.cdb_pr_tag0    = slot0_q.pr;
    assign bus.cdb_pr_tag1    = slot1_q.pr;
    assign bus.cdb_ar_tag0    = slot0_q.ar;
    assign bus.cdb_ar_tag1    = slot1_q.ar;
    assign bus.cdb_exception0 = slot0_q.exc;
    assign bus.cdb_exception1 = slot1_q.exc;
    assign bus.cdb_src0       = src0_q;
    assign bus.cdb_src1       = src1_q;
    assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    cdb_entry_t mq [6][$];
    int         m_rr;
    bit         m_ovf;
    logic [1:0] m_valid;
    cdb_entry_t m_slot [2];
    int         m_src  [2];
    int         sz     [6];
    int         grants [$];
    cdb_entry_t e;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) mq[i].delete();
            m_rr = 0;
            m_ovf = 0;
            m_valid = 2'b00;
            for (int k = 0; k < 2; k++) begin
                m_slot[k] = '0;
                m_src[k] = 0;
            end
        end else if (flush) begin
            for (int i = 0; i < 6; i++) mq[i].delete();
            m_valid = 2'b00;
        end else begin
            for (int i = 0; i < 6; i++) sz[i] = mq[i].size();
            grants.delete();
            for (int k = 0; k < 6; k++) begin
                if (grants.size() < 2 && sz[(m_rr + k) % 6] > 0) grants.push_back((m_rr + k) % 6);
            end
            m_valid = 2'b00;
            for (int n = 0; n < grants.size(); n++) begin
                m_valid[n] = 1'b1;
                m_slot[n] = mq[grants[n]].pop_front();
                m_src[n] = grants[n];
            end
            if (grants.size() > 0) m_rr = (grants[grants.size() - 1] + 1) % 6;
            for (int i = 0; i < 6; i++) begin
                if (bus.src_valid[i]) begin
                    if (sz[i] < 2) begin
                        e.pr  = bus.src_pr_idx[7*i +: 7];
                        e.ar  = bus.src_ar_idx[5*i +: 5];
                        e.exc = (i == 2 || i == 3) ? 1'b0 : bus.src_exception[i];
                        mq[i].push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (check_en) begin
            logic [5:0] exp_ready;
            for (int i = 0; i < 6; i++) exp_ready[i] = (mq[i].size() != 2);
            check("cdb_valid", bus.cdb_valid, m_valid);
            check("src_ready", bus.src_ready, exp_ready);
            check("overflow", bus.overflow, m_ovf);
            check("pr_tag0", bus.cdb_pr_tag0, m_slot[0].pr);
            check("ar_tag0", bus.cdb_ar_tag0, m_slot[0].ar);
            check("exception0", bus.cdb_exception0, m_slot[0].exc);
            check("src0", bus.cdb_src0, m_src[0]);
            check("pr_tag1", bus.cdb_pr_tag1, m_slot[1].pr);
            check("ar_tag1", bus.cdb_ar_tag1, m_slot[1].ar);
            check("exception1", bus.cdb_exception1, m_slot[1].exc);
            check("src1", bus.cdb_src1, m_src[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.src_valid     = '0;
        bus.src_pr_idx    = '0;
        bus.src_ar_idx    = '0;
        bus.src_exception = '0;
        flush             = 1'b0;
    endtask

    task automatic push(input int i, input int pr, input int ar, input bit exc);
        bus.src_valid[i]         = 1'b1;
        bus.src_pr_idx[7*i +: 7] = 7'(pr);
        bus.src_ar_idx[5*i +: 5] = 5'(ar);
        bus.src_exception[i]     = exc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int  mul0_cnt;
    bit  seen_bad;

    task automatic watch(input int src, input int bad_pr);
        if (bus.cdb_valid[0] && bus.cdb_src0 == 3'(src)) mul0_cnt++;
        if (bus.cdb_valid[1] && bus.cdb_src1 == 3'(src)) mul0_cnt++;
        if (bus.cdb_valid[0] && bus.cdb_pr_tag0 == 7'(bad_pr)) seen_bad = 1'b1;
        if (bus.cdb_valid[1] && bus.cdb_pr_tag1 == 7'(bad_pr)) seen_bad = 1'b1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset defaults held with no traffic.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_valid", bus.cdb_valid, 2'b00);
            check("rst_ready", bus.src_ready, 6'h3F);
            check("rst_ovf", bus.overflow, 1'b0);
        end

        // Single push: visible two edges later, then gone.
        push(0, 33, 4, 1'b1);
        tick();
        clear_in();
        check("lat_t1_valid", bus.cdb_valid, 2'b00);
        tick();
        check("lat_valid", bus.cdb_valid, 2'b01);
        check("lat_pr", bus.cdb_pr_tag0, 7'd33);
        check("lat_ar", bus.cdb_ar_tag0, 5'd4);
        check("lat_exc", bus.cdb_exception0, 1'b1);
        check("lat_src", bus.cdb_src0, 3'd0);
        tick();
        check("lat_done", bus.cdb_valid, 2'b00);

        // Six-way contention from rr_ptr = 0.
        do_reset();
        for (int i = 0; i < 6; i++) push(i, 10 + i, i, 1'b0);
        tick();
        clear_in();
        for (int b = 0; b < 3; b++) begin
            tick();
            check("six_valid", bus.cdb_valid, 2'b11);
            check("six_pr0", bus.cdb_pr_tag0, 7'(10 + 2*b));
            check("six_pr1", bus.cdb_pr_tag1, 7'(11 + 2*b));
        end
        tick();
        check("six_idle", bus.cdb_valid, 2'b00);

        // rr_ptr back at 0: sim0 beats mem1.
        push(0, 20, 1, 1'b0);
        push(5, 21, 2, 1'b0);
        tick();
        clear_in();
        tick();
        check("rr0_src0", bus.cdb_src0, 3'd0);
        check("rr0_src1", bus.cdb_src1, 3'd5);
        // mem0 alone moves rr_ptr to 5.
        push(4, 22, 3, 1'b0);
        tick();
        clear_in();
        tick();
        check("mem0_valid", bus.cdb_valid, 2'b01);
        check("mem0_src", bus.cdb_src0, 3'd4);
        // Wrap: mem1 first, then sim0; rr_ptr -> 1.
        push(5, 23, 4, 1'b1);
        push(0, 24, 5, 1'b0);
        tick();
        clear_in();
        tick();
        check("wrap_src0", bus.cdb_src0, 3'd5);
        check("wrap_pr0", bus.cdb_pr_tag0, 7'd23);
        check("wrap_src1", bus.cdb_src1, 3'd0);
        check("wrap_pr1", bus.cdb_pr_tag1, 7'd24);
        push(0, 25, 6, 1'b0);
        push(1, 26, 7, 1'b0);
        tick();
        clear_in();
        tick();
        check("rr1_src0", bus.cdb_src0, 3'd1);
        check("rr1_src1", bus.cdb_src1, 3'd0);

        // Backpressure and overflow on mul0.
        do_reset();
        mul0_cnt = 0;
        seen_bad = 1'b0;
        push(3, 40, 0, 1'b0);
        tick();
        clear_in();
        push(4, 41, 0, 1'b0);
        push(5, 42, 0, 1'b0);
        push(0, 43, 0, 1'b0);
        push(2, 100, 0, 1'b1);
        tick();
        clear_in();
        watch(2, 102);
        check("bp_ready_1", bus.src_ready[2], 1'b1);
        push(2, 101, 0, 1'b0);
        tick();
        clear_in();
        watch(2, 102);
        check("bp_ready_0", bus.src_ready[2], 1'b0);
        check("bp_no_ovf", bus.overflow, 1'b0);
        push(2, 102, 0, 1'b0);
        tick();
        clear_in();
        watch(2, 102);
        check("bp_ovf", bus.overflow, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick();
            watch(2, 102);
        end
        check("bp_mul0_count", mul0_cnt, 2);
        check("bp_dropped_tag", seen_bad, 1'b0);
        check("bp_ovf_sticky", bus.overflow, 1'b1);

        // Flush with queued entries and a concurrent sim1 push.
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 50 + i, i, 1'b0);
        tick();
        clear_in();
        flush = 1'b1;
        push(1, 77, 9, 1'b0);
        tick();
        clear_in();
        check("fl_valid", bus.cdb_valid, 2'b00);
        check("fl_ready", bus.src_ready, 6'h3F);
        check("fl_ovf", bus.overflow, 1'b0);
        seen_bad = 1'b0;
        mul0_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            watch(1, 77);
        end
        check("fl_no_tag", seen_bad, 1'b0);
        check("fl_quiet", bus.cdb_valid, 2'b00);

        // Random traffic with occasional flush and reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int dens;
            dens = (c / 500) % 3;
            bus.src_valid     = (dens == 0) ? 6'($urandom & $urandom) :
                                (dens == 1) ? 6'($urandom) : 6'($urandom | $urandom);
            bus.src_pr_idx    = {$urandom, $urandom};
            bus.src_ar_idx    = 30'($urandom);
            bus.src_exception = 6'($urandom);
            flush             = ($urandom_range(0, 31) == 0);
            reset             = ($urandom_range(0, 299) == 0);
            tick();
        end
        clear_in();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
